// File: rtl/ula_operation_sequencer.sv
// ULA operation sequencer: loads operands A and B, then the operation select and carry, from
// four shared switches, one button press at a time. It drives them onto the ULA inputs and
// lets the combinational result settle. It then snapshots the result and flags for display.
// Optional feature macro: ULA_SEQ_ACC_EN (confirm in DONE feeds result[3:0] back into A).
module ula_operation_sequencer #(
    parameter int unsigned SETTLE_CYCLES = 2,
    parameter int unsigned CNT_W         = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] sw,
    input  logic       btn_confirm,
    input  logic       btn_cancel,
    output logic [3:0] A,
    output logic [3:0] B,
    output logic [2:0] Sel,
    output logic       Cin,
    output logic       Bin,
    input  logic [7:0] S_in,
    input  logic       Z_in,
    input  logic       OV_in,
    input  logic       COUT_in,
    input  logic       ERR_in,
    output logic [7:0] result,
    output logic [3:0] flags,
    output logic       done,
    output logic       busy,
    output logic [2:0] state
);

    typedef enum logic [2:0] {
        StLoadA  = 3'd0,
        StLoadB  = 3'd1,
        StLoadOp = 3'd2,
        StExec   = 3'd3,
        StDone   = 3'd4
    } state_e;

    localparam logic [CNT_W-1:0] CntLast = CNT_W'(SETTLE_CYCLES - 1);

    state_e           state_q, state_d;
    logic [3:0]       a_q, a_d;
    logic [3:0]       b_q, b_d;
    logic [2:0]       sel_q, sel_d;
    logic             carry_q, carry_d;
    logic [7:0]       result_q, result_d;
    logic [3:0]       flags_q, flags_d;
    logic             done_q, done_d;
    logic             busy_q, busy_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             cfm_prev_q, can_prev_q;

    logic cfm, can, clear_ops;

    // Rising-edge detect so a held button acts only once.
    assign cfm = btn_confirm & ~cfm_prev_q;
    assign can = btn_cancel & ~can_prev_q;

    // State and datapath registers, synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= StLoadA;
            a_q        <= '0;
            b_q        <= '0;
            sel_q      <= '0;
            carry_q    <= 1'b0;
            result_q   <= '0;
            flags_q    <= '0;
            done_q     <= 1'b0;
            busy_q     <= 1'b0;
            cnt_q      <= '0;
            cfm_prev_q <= 1'b0;
            can_prev_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            a_q        <= a_d;
            b_q        <= b_d;
            sel_q      <= sel_d;
            carry_q    <= carry_d;
            result_q   <= result_d;
            flags_q    <= flags_d;
            done_q     <= done_d;
            busy_q     <= busy_d;
            cnt_q      <= cnt_d;
            cfm_prev_q <= btn_confirm;
            can_prev_q <= btn_cancel;
        end
    end

    // Next-state and register-update logic; cancel outranks confirm outside EXEC.
    always_comb begin
        state_d   = state_q;
        a_d       = a_q;
        b_d       = b_q;
        sel_d     = sel_q;
        carry_d   = carry_q;
        result_d  = result_q;
        flags_d   = flags_q;
        done_d    = 1'b0;
        cnt_d     = cnt_q;
        clear_ops = 1'b0;

        case (state_q)
            StLoadA: begin
                if (can) begin
                    clear_ops = 1'b1;
                end else if (cfm) begin
                    a_d     = sw;
                    state_d = StLoadB;
                end
            end
            StLoadB: begin
                if (can) begin
                    clear_ops = 1'b1;
                end else if (cfm) begin
                    b_d     = sw;
                    state_d = StLoadOp;
                end
            end
            StLoadOp: begin
                if (can) begin
                    clear_ops = 1'b1;
                end else if (cfm) begin
                    sel_d   = sw[2:0];
                    carry_d = sw[3];
                    cnt_d   = '0;
                    state_d = StExec;
                end
            end
            StExec: begin
                // Cancel is ignored here; the operation always runs to completion.
                cnt_d = cnt_q + CNT_W'(1);
                if (cnt_q == CntLast) begin
                    result_d = S_in;
                    flags_d  = {ERR_in, COUT_in, OV_in, Z_in};
                    done_d   = 1'b1;
                    state_d  = StDone;
                end
            end
            StDone: begin
                if (can) begin
                    clear_ops = 1'b1;
                end else if (cfm) begin
`ifdef ULA_SEQ_ACC_EN
                    a_d     = result_q[3:0];
                    state_d = StLoadB;
`else
                    state_d = StLoadA;
`endif
                end
            end
            default: state_d = StLoadA;
        endcase

        if (clear_ops) begin
            a_d     = '0;
            b_d     = '0;
            sel_d   = '0;
            carry_d = 1'b0;
            state_d = StLoadA;
        end

        busy_d = (state_d == StExec);
    end

    assign A      = a_q;
    assign B      = b_q;
    assign Sel    = sel_q;
    assign Cin    = carry_q;
    assign Bin    = carry_q;
    assign result = result_q;
    assign flags  = flags_q;
    assign done   = done_q;
    assign busy   = busy_q;
    assign state  = state_q;

endmodule

// File: tb/tb_ula_operation_sequencer.sv
// Bench for ula_operation_sequencer: a small ULA model closes the loop, a transaction-level
// model predicts operands and state, and a scoreboard checks every done pulse.
module tb_ula_operation_sequencer;

    localparam int unsigned SETTLE = 2;

    logic       clk = 1'b0;
    logic       rst;
    logic [3:0] sw;
    logic       btn_confirm, btn_cancel;
    logic [3:0] A, B;
    logic [2:0] Sel;
    logic       Cin, Bin;
    logic [7:0] S_in;
    logic       Z_in, OV_in, COUT_in, ERR_in;
    logic [7:0] result;
    logic [3:0] flags;
    logic       done, busy;
    logic [2:0] state;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    ula_operation_sequencer #(.SETTLE_CYCLES(SETTLE), .CNT_W(4)) dut (
        .clk(clk), .rst(rst), .sw(sw), .btn_confirm(btn_confirm), .btn_cancel(btn_cancel),
        .A(A), .B(B), .Sel(Sel), .Cin(Cin), .Bin(Bin), .S_in(S_in), .Z_in(Z_in),
        .OV_in(OV_in), .COUT_in(COUT_in), .ERR_in(ERR_in), .result(result), .flags(flags),
        .done(done), .busy(busy), .state(state)
    );

    // ULA model: returns {ERR, COUT, OV, Z, S[7:0]}.
    function automatic logic [11:0] ula(input logic [3:0] a, input logic [3:0] b,
                                        input logic [2:0] sel, input logic c);
        int ia, ib, ic;
        logic [7:0] s;
        logic err, co, ov, z;
        ia = int'(a); ib = int'(b); ic = int'(c);
        s = 8'd0; err = 1'b0; co = 1'b0; ov = 1'b0;
        case (sel)
            3'd0: begin s = 8'(ia + ib + ic); co = (ia + ib + ic) > 15; end
            3'd1: begin s = 8'(ia - ib - ic); co = ia < (ib + ic); end
            3'd2: begin s = 8'(ia * ib); ov = (ia * ib) > 15; end
            3'd3: begin
                if (ib == 0) err = 1'b1;
                else s = 8'((ia % ib) * 16 + ia / ib);
            end
            3'd4: s = 8'(ia & ib);
            3'd5: s = 8'(ia | ib);
            3'd6: s = 8'(ia ^ ib);
            default: s = 8'(15 - ia);
        endcase
        z = (s == 8'd0);
        return {err, co, ov, z, s};
    endfunction

    assign {ERR_in, COUT_in, OV_in, Z_in, S_in} = ula(A, B, Sel, Cin);

    task automatic chk(input string nm, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Transaction-level reference model.
    int          m_state;
    logic [3:0]  m_a, m_b;
    logic [2:0]  m_sel;
    logic        m_c;
    logic [7:0]  m_res;
    logic [3:0]  m_flags;
    logic [11:0] exp_q[$];

    task automatic model_reset();
        m_state = 0; m_a = '0; m_b = '0; m_sel = '0; m_c = 1'b0;
        m_res = '0; m_flags = '0;
    endtask

    task automatic model_press(input logic c, input logic k, input logic [3:0] v);
        logic [11:0] r;
        if (k) begin
            m_state = 0; m_a = '0; m_b = '0; m_sel = '0; m_c = 1'b0;
        end else if (c) begin
            case (m_state)
                0: begin m_a = v; m_state = 1; end
                1: begin m_b = v; m_state = 2; end
                2: begin
                    m_sel = v[2:0]; m_c = v[3];
                    r = ula(m_a, m_b, m_sel, m_c);
                    m_res = r[7:0]; m_flags = r[11:8];
                    exp_q.push_back(r);
                    m_state = 4;
                end
                default: begin
`ifdef ULA_SEQ_ACC_EN
                    m_a = m_res[3:0]; m_state = 1;
`else
                    m_state = 0;
`endif
                end
            endcase
        end
    endtask

    task automatic drive(input logic c, input logic k, input logic [3:0] v, input int hold);
        @(posedge clk); #1;
        sw = v; btn_confirm = c; btn_cancel = k;
        repeat (hold) @(posedge clk);
        #1; btn_confirm = 1'b0; btn_cancel = 1'b0;
    endtask

    task automatic settle_and_check();
        repeat (SETTLE + 2) @(posedge clk);
        @(negedge clk);
        chk("state", int'(state), m_state);
        chk("A", int'(A), int'(m_a));
        chk("B", int'(B), int'(m_b));
        chk("Sel", int'(Sel), int'(m_sel));
        chk("Cin", int'(Cin), int'(m_c));
        chk("Bin", int'(Bin), int'(m_c));
        chk("result", int'(result), int'(m_res));
        chk("flags", int'(flags), int'(m_flags));
        chk("busy_idle", int'(busy), 0);
        chk("done_idle", int'(done), 0);
    endtask

    task automatic press(input logic c, input logic k, input logic [3:0] v, input int hold);
        model_press(c, k, v);
        drive(c, k, v, hold);
        settle_and_check();
    endtask

    // Confirm the operation, then cancel while EXEC is running.
    task automatic cancel_in_exec(input logic [3:0] v);
        model_press(1'b1, 1'b0, v);
        drive(1'b1, 1'b0, v, 1);
        drive(1'b0, 1'b1, 4'h0, 1);
        settle_and_check();
    endtask

    // Monitor: scoreboards each done pulse and checks EXEC timing and operand stability.
    int   busy_run = 0;
    logic done_prev = 1'b0;
    always @(negedge clk) begin
        logic [11:0] e;
        if (rst) begin
            busy_run = 0;
            done_prev = 1'b0;
        end else begin
            if (busy) begin
                busy_run++;
                chk("exec_A", int'(A), int'(m_a));
                chk("exec_B", int'(B), int'(m_b));
                chk("exec_Sel", int'(Sel), int'(m_sel));
                chk("exec_Bin", int'(Bin), int'(m_c));
            end
            if (done) begin
                chk("settle_len", busy_run, int'(SETTLE));
                chk("done_width", int'(done_prev), 0);
                busy_run = 0;
                if (exp_q.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL unexpected_done: got done=1 expected no pending op at %0t",
                             $time);
                end else begin
                    e = exp_q.pop_front();
                    chk("sb_result", int'(result), int'(e[7:0]));
                    chk("sb_flags", int'(flags), int'(e[11:8]));
                end
            end
            done_prev = done;
        end
    end

    initial begin
        int r;
        logic [3:0] v;
        rst = 1'b1; sw = '0; btn_confirm = 1'b0; btn_cancel = 1'b0;
        model_reset();
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("rst_state", int'(state), 0);
        chk("rst_A", int'(A), 0);
        chk("rst_B", int'(B), 0);
        chk("rst_Sel", int'(Sel), 0);
        chk("rst_result", int'(result), 0);
        chk("rst_flags", int'(flags), 0);
        chk("rst_done", int'(done), 0);
        chk("rst_busy", int'(busy), 0);

        // 5 + 3 add.
        press(1, 0, 4'd5, 1);
        press(1, 0, 4'd3, 2);
        press(1, 0, 4'b0000, 1);
        chk("add_result", int'(result), 8'h08);
        chk("add_flags", int'(flags), 0);
        chk("add_state", int'(state), 4);

        // Confirm in DONE: accumulator chain or return to LOAD_A.
        press(1, 0, 4'hF, 1);
`ifdef ULA_SEQ_ACC_EN
        chk("acc_state", int'(state), 1);
        chk("acc_A", int'(A), 8);
        press(1, 0, 4'd2, 1);
        press(1, 0, 4'b0001, 1);
        chk("acc_sub_result", int'(result), 8'h06);
        press(0, 1, 4'h0, 1);
`else
        chk("noacc_state", int'(state), 0);
        chk("noacc_A", int'(A), 5);
`endif

        // Divide by zero: ERR captured, DONE reached.
        press(1, 0, 4'd9, 1);
        press(1, 0, 4'd0, 1);
        press(1, 0, 4'b0011, 1);
        chk("div0_err", int'(flags[3]), 1);
        chk("div0_state", int'(state), 4);
        press(0, 1, 4'h0, 1);

        // Cancel in LOAD_OP keeps the previous result.
        press(1, 0, 4'd7, 1);
        press(1, 0, 4'd2, 1);
        press(0, 1, 4'h0, 1);
        chk("cancel_result_kept", int'(flags[3]), 1);

        // Confirm and cancel together in LOAD_B: cancel wins.
        press(1, 0, 4'd6, 1);
        press(1, 1, 4'd4, 1);
        chk("both_B", int'(B), 0);

        // Cancel during EXEC is ignored.
        press(1, 0, 4'd3, 1);
        press(1, 0, 4'd4, 1);
        cancel_in_exec(4'b0010);
        chk("exec_cancel_result", int'(result), 8'h0C);
        press(0, 1, 4'h0, 1);

        // Reset during EXEC: no done, result cleared.
        press(1, 0, 4'd2, 1);
        press(1, 0, 4'd2, 1);
        m_sel = 3'd0; m_c = 1'b0;
        drive(1'b1, 1'b0, 4'b0000, 1);
        rst = 1'b1;
        @(posedge clk); #1 rst = 1'b0;
        model_reset();
        settle_and_check();

        // Random phase.
        for (int i = 0; i < 200; i++) begin
            r = int'($urandom_range(0, 9));
            v = 4'($urandom);
            if (r <= 5) press(1, 0, v, int'($urandom_range(1, 3)));
            else if (r <= 7) press(0, 1, v, int'($urandom_range(1, 3)));
            else if (r == 8) press(1, 1, v, 1);
            else if (m_state == 2) cancel_in_exec(v);
            else press(1, 0, v, 1);
            repeat ($urandom_range(0, 2)) @(posedge clk);
        end

        repeat (SETTLE + 4) @(posedge clk);
        @(negedge clk);
        chk("sb_drained", exp_q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
